// File: rtl/led_seq_if.sv
// led_seq_if -- bundles the LED sequencer's run enable, ROM port and LED outputs.
//   en         : run enable (low freezes the engine)
//   addrRd     : ROM read address, driven by the engine
//   dataRd     : ROM word for addrRd, returned combinationally by the ROM
//   outPattern : LED drive, driven by the engine
//   halted     : high while the engine sits in HALT
// Modports: master = the ROM/host side, slave = the engine.
interface led_seq_if #(
  parameter int PW = 8,
  parameter int DW = 8,
  parameter int AW = 8
);
  localparam int IW = PW + DW + 2;

  logic          en;
  logic [AW-1:0] addrRd;
  logic [IW-1:0] dataRd;
  logic [PW-1:0] outPattern;
  logic          halted;

  modport master (output en, output dataRd, input addrRd, input outPattern, input halted);
  modport slave  (input en, input dataRd, output addrRd, output outPattern, output halted);
endinterface

// File: rtl/led_seq_engine.sv
// led_seq_engine -- steps through an instruction ROM and drives an LED pattern.
// Instruction word: {opcode[1:0], F[PW-1:0], D[DW-1:0]}
//   00 SHOW(F=pattern, D=duration ticks)   01 JUMP(D=target)
//   10 LOOP(F=count, D=target)             11 HALT
// Ports:
//   clk : clock, all updates on its rising edge
//   rst : synchronous active-high reset, overrides en
//   bus : led_seq_if slave (en, addrRd, dataRd, outPattern, halted)
//
// state | meaning
// FETCH | decode the word at addrRd, act on it at the end of the cycle
// SHOW  | hold pattern until D ticks of TICK_DIV clocks have elapsed
// HALT  | stopped, outputs held until rst
module led_seq_engine #(
  parameter int PW       = 8,
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int TICK_DIV = 3_125_000
) (
  input  logic   clk,
  input  logic   rst,
  led_seq_if.slave bus
);
  localparam int IW  = PW + DW + 2;
  localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PSW-1:0] PS_LAST = PSW'(TICK_DIV - 1);

  typedef enum logic [1:0] {FETCH, SHOW, HALT} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [PW-1:0]  pat_q, pat_d;
  logic [PSW-1:0] presc_q, presc_d;
  logic [DW-1:0]  tick_q, tick_d;
  logic           loop_busy_q, loop_busy_d;
  logic [DW-1:0]  loop_rem_q, loop_rem_d;

  logic [1:0]    opc;
  logic [PW-1:0] f_fld;
  logic [DW-1:0] d_fld;
  logic [AW-1:0] tgt;

  assign opc   = bus.dataRd[IW-1:IW-2];
  assign f_fld = bus.dataRd[PW+DW-1:DW];
  assign d_fld = bus.dataRd[DW-1:0];
  assign tgt   = d_fld[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      addr_q      <= '0;
      pat_q       <= '0;
      presc_q     <= '0;
      tick_q      <= '0;
      loop_busy_q <= 1'b0;
      loop_rem_q  <= '0;
    end else if (bus.en) begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pat_q       <= pat_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      loop_busy_q <= loop_busy_d;
      loop_rem_q  <= loop_rem_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pat_d       = pat_q;
    presc_d     = presc_q;
    tick_d      = tick_q;
    loop_busy_d = loop_busy_q;
    loop_rem_d  = loop_rem_q;
    case (state_q)
      FETCH: begin
        case (opc)
          2'b00: begin
            if (d_fld != '0) begin
              pat_d   = f_fld;
              presc_d = '0;
              tick_d  = '0;
              state_d = SHOW;
            end else begin
              // zero-length show is a one-cycle skip
              addr_d = addr_q + AW'(1);
            end
          end
          2'b01: addr_d = tgt;
          2'b10: begin
            // single shared loop register pair; inner loops clobber outer ones
            if (!loop_busy_q) begin
              if (f_fld == '0) begin
                addr_d = addr_q + AW'(1);
              end else begin
                loop_busy_d = 1'b1;
                loop_rem_d  = DW'(f_fld - PW'(1));
                addr_d      = tgt;
              end
            end else if (loop_rem_q == '0) begin
              loop_busy_d = 1'b0;
              addr_d      = addr_q + AW'(1);
            end else begin
              loop_rem_d = loop_rem_q - DW'(1);
              addr_d     = tgt;
            end
          end
          default: state_d = HALT;
        endcase
      end
      SHOW: begin
        if (presc_q == PS_LAST) begin
          presc_d = '0;
          // D is re-read every cycle; the show ends on tick number D
          if (tick_q == d_fld - DW'(1)) begin
            addr_d  = addr_q + AW'(1);
            state_d = FETCH;
          end else begin
            tick_d = tick_q + DW'(1);
          end
        end else begin
          presc_d = presc_q + PSW'(1);
        end
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  assign bus.addrRd     = addr_q;
  assign bus.outPattern = pat_q;
  assign bus.halted     = (state_q == HALT);
endmodule

// File: tb/tb_led_seq_engine.sv
module tb_led_seq_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_seq_if #(.PW(8), .DW(8), .AW(8)) bus ();

  led_seq_engine #(.PW(8), .DW(8), .AW(8), .TICK_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [17:0] rom [256];
  assign bus.dataRd = rom[bus.addrRd];

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [7:0] pat;
    logic       halted;
  } vec_t;

  vec_t vq[$];
  int   cyc;
  int   n_chk = 0;
  int   n_err = 0;

  function automatic logic [17:0] i_show(input logic [7:0] p, input logic [7:0] d);
    return {2'b00, p, d};
  endfunction
  function automatic logic [17:0] i_jump(input logic [7:0] t);
    return {2'b01, 8'h00, t};
  endfunction
  function automatic logic [17:0] i_loop(input logic [7:0] n, input logic [7:0] t);
    return {2'b10, n, t};
  endfunction
  function automatic logic [17:0] i_halt();
    return {2'b11, 16'h0000};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] a, input logic [7:0] p, input logic h);
    chk({tag, ".addrRd"}, bus.addrRd, a);
    chk({tag, ".outPattern"}, bus.outPattern, p);
    chk({tag, ".halted"}, {7'b0, bus.halted}, {7'b0, h});
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = i_halt();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.en = 1'b1;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic apply_vectors(input string tag);
    foreach (vq[k]) begin
      while (cyc < vq[k].cyc) step();
      chk_all(tag, vq[k].addr, vq[k].pat, vq[k].halted);
    end
    vq.delete();
  endtask

  initial begin
    bus.en = 1'b1;
    clear_rom();

    // show 0xA5 for 3 ticks then halt
    rom[0] = i_show(8'hA5, 8'd3);
    rom[1] = i_halt();
    do_reset();
    chk("reset.loop_busy", {7'b0, dut.loop_busy_q}, 8'h00);
    vq.push_back('{0,  8'h00, 8'h00, 1'b0});
    vq.push_back('{1,  8'h00, 8'hA5, 1'b0});
    vq.push_back('{12, 8'h00, 8'hA5, 1'b0});
    vq.push_back('{13, 8'h01, 8'hA5, 1'b0});
    vq.push_back('{14, 8'h01, 8'hA5, 1'b1});
    vq.push_back('{20, 8'h01, 8'hA5, 1'b1});
    apply_vectors("show3");

    // zero-duration skip then one-tick show
    clear_rom();
    rom[0] = i_show(8'h11, 8'd0);
    rom[1] = i_show(8'h22, 8'd1);
    do_reset();
    vq.push_back('{1, 8'h01, 8'h00, 1'b0});
    vq.push_back('{2, 8'h01, 8'h22, 1'b0});
    vq.push_back('{5, 8'h01, 8'h22, 1'b0});
    vq.push_back('{6, 8'h02, 8'h22, 1'b0});
    vq.push_back('{7, 8'h02, 8'h22, 1'b1});
    apply_vectors("skip");

    // loop body runs N+1 = 3 times
    clear_rom();
    rom[0] = i_show(8'h01, 8'd1);
    rom[1] = i_loop(8'd2, 8'd0);
    do_reset();
    vq.push_back('{5,  8'h01, 8'h01, 1'b0});
    vq.push_back('{6,  8'h00, 8'h01, 1'b0});
    vq.push_back('{7,  8'h00, 8'h01, 1'b0});
    vq.push_back('{11, 8'h01, 8'h01, 1'b0});
    vq.push_back('{12, 8'h00, 8'h01, 1'b0});
    vq.push_back('{17, 8'h01, 8'h01, 1'b0});
    vq.push_back('{18, 8'h02, 8'h01, 1'b0});
    vq.push_back('{19, 8'h02, 8'h01, 1'b1});
    apply_vectors("loop");
    chk("loop.loop_busy_at_halt", {7'b0, dut.loop_busy_q}, 8'h00);

    // LOOP with N=0 falls through
    clear_rom();
    rom[0] = i_loop(8'd0, 8'd5);
    do_reset();
    vq.push_back('{1, 8'h01, 8'h00, 1'b0});
    vq.push_back('{2, 8'h01, 8'h00, 1'b1});
    apply_vectors("loop0");

    // jump to 255, show, wrap to 0
    clear_rom();
    rom[0]   = i_jump(8'd255);
    rom[255] = i_show(8'h80, 8'd1);
    do_reset();
    vq.push_back('{1, 8'hFF, 8'h00, 1'b0});
    vq.push_back('{2, 8'hFF, 8'h80, 1'b0});
    vq.push_back('{5, 8'hFF, 8'h80, 1'b0});
    vq.push_back('{6, 8'h00, 8'h80, 1'b0});
    vq.push_back('{7, 8'hFF, 8'h80, 1'b0});
    apply_vectors("wrap");

    // skip at 254 keeps the pattern, jump at 255 returns to 0
    clear_rom();
    rom[0]   = i_show(8'h3C, 8'd1);
    rom[1]   = i_jump(8'd254);
    rom[254] = i_show(8'h55, 8'd0);
    rom[255] = i_jump(8'd0);
    do_reset();
    vq.push_back('{5, 8'h01, 8'h3C, 1'b0});
    vq.push_back('{6, 8'hFE, 8'h3C, 1'b0});
    vq.push_back('{7, 8'hFF, 8'h3C, 1'b0});
    vq.push_back('{8, 8'h00, 8'h3C, 1'b0});
    vq.push_back('{9, 8'h00, 8'h3C, 1'b0});
    apply_vectors("skipwrap");

    // freeze mid-show for 10 cycles: 9 + 10 cycle show
    clear_rom();
    rom[0] = i_show(8'h5A, 8'd2);
    do_reset();
    while (cyc < 4) step();
    bus.en = 1'b0;
    repeat (10) step();
    chk_all("freeze.held", 8'h00, 8'h5A, 1'b0);
    bus.en = 1'b1;
    while (cyc < 18) step();
    chk_all("freeze.end-1", 8'h00, 8'h5A, 1'b0);
    step();
    chk_all("freeze.end", 8'h01, 8'h5A, 1'b0);
    step();
    chk_all("freeze.halt", 8'h01, 8'h5A, 1'b1);

    // reset out of HALT, with en low to show rst wins
    bus.en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all("rst_halt", 8'h00, 8'h00, 1'b0);
    bus.en = 1'b1;

    // reset mid-show, then a clean rerun from address 0
    clear_rom();
    rom[0] = i_jump(8'd2);
    rom[2] = i_show(8'h5A, 8'd2);
    do_reset();
    while (cyc < 4) step();
    chk_all("rst_show.pre", 8'h02, 8'h5A, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
    chk_all("rst_show.post", 8'h00, 8'h00, 1'b0);
    vq.push_back('{1,  8'h02, 8'h00, 1'b0});
    vq.push_back('{2,  8'h02, 8'h5A, 1'b0});
    vq.push_back('{9,  8'h02, 8'h5A, 1'b0});
    vq.push_back('{10, 8'h03, 8'h5A, 1'b0});
    vq.push_back('{11, 8'h03, 8'h5A, 1'b1});
    apply_vectors("rerun");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/led_seq_engine.md
LED_SEQ_ENGINE -- requirements
Module: led_seq_engine

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- PW, 8, pattern width.
- DW, 8, duration and loop-count field width.
- AW, 8, ROM address width.
- TICK_DIV, 3_125_000, clk cycles per duration tick.
- Legal ranges: AW <= DW; TICK_DIV >= 1.
REQ-002 Instruction word width IW = PW+DW+2.
- dataRd[IW-1:IW-2] is the opcode.
- dataRd[PW+DW-1:DW] is field F (pattern or loop count).
- dataRd[DW-1:0] is field D (duration or target; a target uses D[AW-1:0]).
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, synchronous active-high reset.
- en, in, 1, run enable; low freezes all state.
- addrRd, out, AW, ROM read address (registered).
- dataRd, in, IW, ROM word; asynchronous read, valid in the same cycle as addrRd.
- outPattern, out, PW, LED drive (registered).
- halted, out, 1, high while in HALT.

Function
REQ-004 The FSM SHALL have exactly the states FETCH, SHOW and HALT.
REQ-005 Opcodes:
- 00 SHOW(F=pattern, D=duration).
- 01 JUMP(D=target).
- 10 LOOP(F=count N, D=target).
- 11 HALT.
REQ-006 FETCH SHALL decode dataRd in one cycle; every opcode action takes effect at the end of that cycle.
REQ-007 SHOW with D!=0:
- outPattern<=F, prescaler<=0, tick counter<=0, next state SHOW.
REQ-008 SHOW with D==0:
- outPattern unchanged, addrRd<=addrRd+1, stay in FETCH (1 cycle total).
REQ-009 In SHOW:
- The prescaler SHALL count 0..TICK_DIV-1, then wrap to 0 with a one-cycle tick.
- Each tick SHALL increment the tick counter.
- On the tick where tick counter == D-1: addrRd<=addrRd+1 and next state FETCH.
- D is re-read from dataRd each cycle; addrRd is stable during SHOW.
REQ-010 A SHOW instruction with D!=0 SHALL occupy exactly 1 + D*TICK_DIV enabled cycles.
REQ-011 JUMP SHALL set addrRd<=D[AW-1:0] and remain in FETCH; outPattern is unchanged.
REQ-012 LOOP (single level; registers loop_busy and loop_rem of DW bits):
- !loop_busy and N==0: addrRd+1.
- !loop_busy and N!=0: loop_busy<=1, loop_rem<=N-1, addrRd<=target.
- loop_busy and loop_rem==0: loop_busy<=0, addrRd+1.
- loop_busy and loop_rem!=0: loop_rem-1, addrRd<=target.
- Net effect: the loop body executes N+1 times.
REQ-013 Nested LOOP instructions SHALL share the single loop_busy/loop_rem pair; no loop stack is provided.
REQ-014 HALT SHALL enter the HALT state with halted=1, addrRd and outPattern held; only rst exits HALT.
REQ-015 addrRd increments SHALL wrap modulo 2^AW (all-ones+1 -> 0) with no other side effect.
REQ-016 With en=0, every register SHALL hold its value (state, prescaler, tick counter, loop regs, outputs).
- Resumption with en=1 SHALL continue cycle-exactly.
REQ-017 rst SHALL take priority over en and over every state, including mid-SHOW and HALT.

Reset
REQ-018 When rst=1 at a clk edge, the following SHALL hold from the next edge:
- addrRd=0, outPattern=0, halted=0.
- state=FETCH, prescaler=0, tick counter=0, loop_busy=0, loop_rem=0.
REQ-019 After rst is released, the first FETCH SHALL decode address 0 in the first enabled cycle.

Verification (TICK_DIV=4, PW=DW=AW=8, en=1 unless stated)
REQ-020 ROM[0]=SHOW(0xA5,3), ROM[1]=HALT:
- outPattern=0xA5 from cycle 1 through cycle 12.
- addrRd=1 at cycle 13; halted=1 from cycle 14 and held.
REQ-021 ROM[0]=SHOW(0x11,0), ROM[1]=SHOW(0x22,1):
- addrRd=1 after 1 cycle, outPattern still 0.
- outPattern=0x22 one cycle later, for 4 cycles.
REQ-022 ROM[0]=SHOW(0x01,1), ROM[1]=LOOP(N=2, target 0), ROM[2]=HALT:
- 0x01 is shown for 3 separate 4-cycle windows.
- Then addrRd=2 and halted=1; loop_busy=0 at halt.
REQ-023 Wrap and jump:
- ROM[255]=SHOW(0x80,1) reached via JUMP(255) at ROM[0]: after the show, addrRd wraps to 0.
- ROM[254]=SHOW(0x55,0), ROM[255]=JUMP(0): the D==0 skip does not alter outPattern.
REQ-024 Freeze and reset:
- Drop en for 10 cycles mid-SHOW(D=2): total show length becomes 9+10 cycles and the pattern is held.
- Assert rst mid-SHOW: the next cycle has addrRd=0 and outPattern=0.
- Assert rst in HALT: halted clears.
